// File: rtl/i2s_receiver.sv
// Slave-mode I2S receiver: synchronises BCLK/LRCK/SDATA to the system clock and deserialises
// MSB-first stereo frames into one L/R pair per frame. Define I2S_RX_ERR_EN to enable short-word err.
module i2s_receiver #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SYNC  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i2s_bc,
  input  logic             i2s_lc,
  input  logic             i2s_dt,
  output logic [WIDTH-1:0] l_data,
  output logic [WIDTH-1:0] r_data,
  output logic             valid,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] W_C  = CW'(WIDTH);
  localparam logic [CW-1:0] W1_C = CW'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  logic [SYNC-1:0]  bc_sync_q, bc_sync_d;
  logic [SYNC-1:0]  lc_sync_q, lc_sync_d;
  logic [SYNC-1:0]  dt_sync_q, dt_sync_d;
  logic             bc_prev_q, bc_prev_d;
  logic             rise_q, rise_d;
  logic             lc_smp_q, lc_smp_d;
  logic             dt_smp_q, dt_smp_d;
  logic             lc_prev_q, lc_prev_d;
  state_t           state_q, state_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] l_hold_q, l_hold_d;
  logic [WIDTH-1:0] l_data_q, l_data_d;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
`ifdef I2S_RX_ERR_EN
  logic             l_flag_q, l_flag_d;
`endif

  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;
  logic             short_word;

  // Synchronisers plus a registered edge strobe; lc/dt are registered alongside so all three
  // arrive aligned with rise_q.
  always_comb begin
    bc_sync_d = {bc_sync_q[SYNC-2:0], i2s_bc};
    lc_sync_d = {lc_sync_q[SYNC-2:0], i2s_lc};
    dt_sync_d = {dt_sync_q[SYNC-2:0], i2s_dt};
    bc_prev_d = bc_sync_q[SYNC-1];
    rise_d    = bc_sync_q[SYNC-1] & ~bc_prev_q;
    lc_smp_d  = lc_sync_q[SYNC-1];
    dt_smp_d  = dt_sync_q[SYNC-1];
  end

  always_comb begin
    cnt_inc    = (bitcnt_q < W1_C) ? bitcnt_q + 1'b1 : bitcnt_q;
    sr_shift   = (bitcnt_q < W_C) ? {sr_q[WIDTH-2:0], dt_smp_q} : sr_q;
    short_word = (cnt_inc < W_C);
    word       = short_word ? (sr_shift << (W_C - cnt_inc)) : sr_shift;
  end

  always_comb begin
    lc_prev_d = lc_prev_q;
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    sr_d      = sr_q;
    l_hold_d  = l_hold_q;
    l_data_d  = l_data_q;
    r_data_d  = r_data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef I2S_RX_ERR_EN
    l_flag_d  = l_flag_q;
`endif
    if (rise_q) begin
      lc_prev_d = lc_smp_q;
      sr_d      = sr_shift;
      bitcnt_d  = cnt_inc;
      // The bit taken on the rise where lc flips still belongs to the old channel.
      if (lc_smp_q != lc_prev_q) begin
        sr_d     = '0;
        bitcnt_d = '0;
        case (state_q)
          IDLE: begin
            if (!lc_smp_q) state_d = LEFT;
          end
          LEFT: begin
            if (lc_smp_q) begin
              l_hold_d = word;
              state_d  = RIGHT;
`ifdef I2S_RX_ERR_EN
              l_flag_d = short_word;
`endif
            end
          end
          RIGHT: begin
            if (!lc_smp_q) begin
              l_data_d = l_hold_q;
              r_data_d = word;
              valid_d  = 1'b1;
              state_d  = LEFT;
`ifdef I2S_RX_ERR_EN
              err_d    = l_flag_q | short_word;
              l_flag_d = 1'b0;
`endif
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bc_sync_q <= '0;
      lc_sync_q <= '0;
      dt_sync_q <= '0;
      bc_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      lc_smp_q  <= 1'b0;
      dt_smp_q  <= 1'b0;
      lc_prev_q <= 1'b0;
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      sr_q      <= '0;
      l_hold_q  <= '0;
      l_data_q  <= '0;
      r_data_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef I2S_RX_ERR_EN
      l_flag_q  <= 1'b0;
`endif
    end else begin
      bc_sync_q <= bc_sync_d;
      lc_sync_q <= lc_sync_d;
      dt_sync_q <= dt_sync_d;
      bc_prev_q <= bc_prev_d;
      rise_q    <= rise_d;
      lc_smp_q  <= lc_smp_d;
      dt_smp_q  <= dt_smp_d;
      lc_prev_q <= lc_prev_d;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      sr_q      <= sr_d;
      l_hold_q  <= l_hold_d;
      l_data_q  <= l_data_d;
      r_data_q  <= r_data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef I2S_RX_ERR_EN
      l_flag_q  <= l_flag_d;
`endif
    end
  end

  assign l_data = l_data_q;
  assign r_data = r_data_q;
  assign valid  = valid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: drives I2S frames, queues expected pairs at each closing
// BCLK rise and checks values, err and latency when valid strobes.
module tb_i2s_receiver;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned HALF  = 4;
  localparam int unsigned N_VALID = 13;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i2s_bc = 1'b0;
  logic i2s_lc = 1'b0;
  logic i2s_dt = 1'b0;
  logic [WIDTH-1:0] l_data, r_data;
  logic valid, err;

  i2s_receiver #(.WIDTH(WIDTH), .SYNC(SYNC)) dut (
    .clock(clock), .reset(reset), .i2s_bc(i2s_bc), .i2s_lc(i2s_lc), .i2s_dt(i2s_dt),
    .l_data(l_data), .r_data(r_data), .valid(valid), .err(err)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        e;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned nvalid = 0;
  logic        done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] align(input int n, input logic [31:0] w);
    if (n >= 16) return 16'(w >> (n - 16));
    else         return 16'(w << (16 - n));
  endfunction

  function automatic logic err_model(input int n);
`ifdef I2S_RX_ERR_EN
    return (n < 16);
`else
    return (n < 0);
`endif
  endfunction

  task automatic slot(input logic lc, input logic dt, input bit push, input exp_t e);
    exp_t t;
    t = e;
    @(negedge clock);
    i2s_bc = 1'b0;
    i2s_lc = lc;
    i2s_dt = dt;
    repeat (HALF) @(negedge clock);
    i2s_bc = 1'b1;
    if (push) begin
      t.cyc = cyc;
      sb.push_back(t);
    end
    repeat (HALF - 1) @(negedge clock);
  endtask

  // n slots per channel; left slot 0 is the previous frame's closing slot.
  task automatic send_frame(input int n, input logic [31:0] l, input logic [31:0] r, input bit push);
    exp_t e;
    e.l = align(n, l);
    e.r = align(n, r);
    e.e = err_model(n);
    e.cyc = 0;
    for (int k = 1; k < n; k++) slot(1'b0, l[n-k], 1'b0, e);
    slot(1'b1, l[0], 1'b0, e);
    for (int k = 1; k < n; k++) slot(1'b1, r[n-k], 1'b0, e);
    slot(1'b0, r[0], push, e);
  endtask

  task automatic preamble();
    exp_t e;
    e.l = '0; e.r = '0; e.e = 1'b0; e.cyc = 0;
    slot(1'b1, 1'b0, 1'b0, e);
    slot(1'b1, 1'b0, 1'b0, e);
    slot(1'b0, 1'b0, 1'b0, e);
  endtask

  initial begin : monitor
    logic prev_v;
    logic rst_at;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(posedge clock);
      rst_at = reset;
      cyc++;
      #1;
      if (rst_at) begin
        check("rst_l_data", 32'(l_data), 32'h0);
        check("rst_r_data", 32'(r_data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
      end else if (valid) begin
        nvalid++;
        check("valid_1clk", 32'(prev_v), 32'h0);
        check("sb_nonempty", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("l_data", 32'(l_data), 32'(e.l));
          check("r_data", 32'(r_data), 32'(e.r));
          check("err", 32'(err), 32'(e.e));
          check("latency", cyc - e.cyc, SYNC + 2);
        end
      end
      prev_v = valid;
      if (done) begin
        check("sb_drained", 32'(sb.size()), 32'h0);
        check("valid_count", nvalid, N_VALID);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (5) @(negedge clock);
    reset = 1'b0;
    preamble();
    send_frame(16, 32'hA55A, 32'h1234, 1'b1);

    repeat (8) @(negedge clock);
    reset = 1'b1;
    fork
      send_frame(16, 32'h5555, 32'h6666, 1'b0);
      begin
        repeat (24 * 2 * HALF) @(negedge clock);
        reset = 1'b0;
      end
    join
    send_frame(16, 32'h0001, 32'h8000, 1'b1);

    send_frame(24, 32'hABCDEF, 32'h123456, 1'b1);
    send_frame(12, 32'hFFF, 32'h801, 1'b1);

    fork
      send_frame(16, 32'h7777, 32'h8888, 1'b0);
      begin
        repeat (5 * 2 * HALF) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
      end
    join
    send_frame(16, 32'h0F0F, 32'hF0F0, 1'b1);

    for (int i = 0; i < 8; i++)
      send_frame(16, 32'h1000 + 32'(i) * 32'h111, 32'hF000 - 32'(i) * 32'h101, 1'b1);

    repeat (10) @(negedge clock);
    done = 1'b1;
  end

endmodule
